// File: rtl/seq_alu.sv
// Multi-cycle RV32I/M execution unit: 1-cycle base ops, iterative MUL/DIV behind valid/ready.
// SEQ_ALU_FAST_MUL_EN selects a single-cycle multiplier for ops 10-13 instead of the iterative one.
module seq_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  input  logic [4:0]      OP,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            ISEQUAL
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned PW  = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DIV  = 2'd3;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            iseq_q, iseq_n;
  logic            in_ready_q, in_ready_n;
  logic            out_valid_q, out_valid_n;
  logic [SHW-1:0]  cnt, cnt_n;
  logic [4:0]      op_q, op_n;
  logic            neg_q, neg_n;
  logic            rneg_q, rneg_n;
  logic [XLEN-1:0] opa_q, opa_n;
  // mul: running product; div: {remainder, quotient/dividend}
  logic [PW-1:0]   acc_q, acc_n;

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
  assign ISEQUAL   = iseq_q;

  // Operand decode at accept time
  logic            is_mul, is_div, div_s, is_quot, sa, sb, div_zero, div_ovf, acc_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;

  assign is_mul   = (OP >= OP_MUL) && (OP <= OP_MULHU);
  assign is_div   = (OP >= OP_DIV) && (OP <= OP_REMU);
  assign div_s    = (OP == OP_DIV) || (OP == OP_REM);
  assign is_quot  = (OP == OP_DIV) || (OP == OP_DIVU);
  assign sa       = (OP == OP_MULH) || (OP == OP_MULHSU) || div_s;
  assign sb       = (OP == OP_MULH) || div_s;
  assign a_mag    = (sa && X[XLEN-1]) ? -X : X;
  assign b_mag    = (sb && Y[XLEN-1]) ? -Y : Y;
  assign acc_neg  = (sa && X[XLEN-1]) ^ (sb && Y[XLEN-1]);
  assign div_zero = (Y == '0);
  assign div_ovf  = div_s && (X == MIN_VAL) && (Y == '1);
  assign shamt    = Y[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (OP)
      OP_ADD:  base_res = X + Y;
      OP_SUB:  base_res = X - Y;
      OP_AND:  base_res = X & Y;
      OP_OR:   base_res = X | Y;
      OP_XOR:  base_res = X ^ Y;
      OP_SLL:  base_res = X << shamt;
      OP_SRL:  base_res = X >> shamt;
      OP_SRA:  base_res = XLEN'($signed(X) >>> shamt);
      OP_SLT:  base_res = XLEN'($signed(X) < $signed(Y));
      OP_SLTU: base_res = XLEN'(X < Y);
      default: base_res = '0;
    endcase
  end

  // One radix-2 multiply step: conditionally add multiplicand to upper half, shift right
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_nx, mul_fin;
  logic [XLEN-1:0] mul_res;
  assign mul_sum = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, (acc_q[0] ? opa_q : '0)};
  assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_fin = neg_q ? -mul_nx : mul_nx;
  assign mul_res = (op_q == OP_MUL) ? mul_fin[XLEN-1:0] : mul_fin[PW-1:XLEN];

  // One restoring divide step on magnitudes; signs applied on the final step
  logic [XLEN:0]   div_sh, div_tr;
  logic            div_ge;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin, div_res;
  assign div_sh  = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
  assign div_tr  = div_sh - {1'b0, opa_q};
  assign div_ge  = ~div_tr[XLEN];
  assign rem_nx  = div_ge ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];
  assign quo_nx  = {acc_q[XLEN-2:0], div_ge};
  assign quo_fin = neg_q ? -quo_nx : quo_nx;
  assign rem_fin = rneg_q ? -rem_nx : rem_nx;
  assign div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fin : rem_fin;

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [PW-1:0]   fast_p, fast_f;
  logic [XLEN-1:0] fast_res;
  assign fast_p   = PW'(a_mag) * PW'(b_mag);
  assign fast_f   = acc_neg ? -fast_p : fast_p;
  assign fast_res = (OP == OP_MUL) ? fast_f[XLEN-1:0] : fast_f[PW-1:XLEN];
`endif

  // Next-state and datapath update
  always_comb begin
    state_n  = state;
    result_n = result_q;
    iseq_n   = iseq_q;
    cnt_n    = cnt;
    op_n     = op_q;
    neg_n    = neg_q;
    rneg_n   = rneg_q;
    opa_n    = opa_q;
    acc_n    = acc_q;
    case (state)
      S_IDLE: begin
        if (IN_VALID) begin
          op_n   = OP;
          iseq_n = (X == Y);
          cnt_n  = '0;
          if (is_mul) begin
`ifdef SEQ_ALU_FAST_MUL_EN
            result_n = fast_res;
            state_n  = S_DONE;
`else
            neg_n   = acc_neg;
            opa_n   = a_mag;
            acc_n   = {{XLEN{1'b0}}, b_mag};
            state_n = S_MUL;
`endif
          end else if (is_div) begin
            if (div_zero) begin
              result_n = is_quot ? '1 : X;
              state_n  = S_DONE;
            end else if (div_ovf) begin
              result_n = is_quot ? MIN_VAL : '0;
              state_n  = S_DONE;
            end else begin
              neg_n   = acc_neg;
              rneg_n  = div_s && X[XLEN-1];
              opa_n   = b_mag;
              acc_n   = {{XLEN{1'b0}}, a_mag};
              state_n = S_DIV;
            end
          end else begin
            result_n = base_res;
            state_n  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_n = mul_nx;
        cnt_n = cnt + SHW'(1);
        if (cnt == SHW'(XLEN - 1)) begin
          result_n = mul_res;
          state_n  = S_DONE;
        end
      end
      S_DIV: begin
        acc_n = {rem_nx, quo_nx};
        cnt_n = cnt + SHW'(1);
        if (cnt == SHW'(XLEN - 1)) begin
          result_n = div_res;
          state_n  = S_DONE;
        end
      end
      default: begin
        if (OUT_READY) state_n = S_IDLE;
      end
    endcase
    // Abort keeps the previously presented result and flag
    if (FLUSH) begin
      state_n  = S_IDLE;
      result_n = result_q;
      iseq_n   = iseq_q;
      cnt_n    = '0;
    end
    in_ready_n  = (state_n == S_IDLE);
    out_valid_n = (state_n == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      result_q    <= '0;
      iseq_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      opa_q       <= '0;
      acc_q       <= '0;
    end else begin
      state       <= state_n;
      result_q    <= result_n;
      iseq_q      <= iseq_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      cnt         <= cnt_n;
      op_q        <= op_n;
      neg_q       <= neg_n;
      rneg_q      <= rneg_n;
      opa_q       <= opa_n;
      acc_q       <= acc_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases, random ops, backpressure, flush and reset abort.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic [4:0]  OP = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] RESULT;
  logic        ISEQUAL;

  seq_alu #(.XLEN(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .ISEQUAL(ISEQUAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        iseq;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  localparam logic [31:0] MINV = 32'h8000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic        [63:0] up;
    logic signed [31:0] x32, y32;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    uy  = {32'b0, y};
    x32 = x;
    y32 = y;
    up  = {32'b0, x} * {32'b0, y};
    case (op)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return 32'(x32 >>> y[4:0]);
      5'd8:  return (x32 < y32) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: begin p = sx * sy; return p[31:0]; end
      5'd11: begin p = sx * sy; return p[63:32]; end
      5'd12: begin p = sx * uy; return p[63:32]; end
      5'd13: return up[63:32];
      5'd14: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MINV && y == 32'hFFFF_FFFF) return MINV;
        return 32'(x32 / y32);
      end
      5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd16: begin
        if (y == 0) return x;
        if (x == MINV && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(x32 % y32);
      end
      5'd17: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op >= 5'd10 && op <= 5'd13) begin
`ifdef SEQ_ALU_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (op >= 5'd14 && op <= 5'd17) begin
      if (y == 0) return 1;
      if ((op == 5'd14 || op == 5'd16) && x == MINV && y == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Accept one op without expecting a result (used for aborted ops)
  task automatic start_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge CLK);
    OP = op; X = x; Y = y; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic issue_wait(input string tag, input logic [4:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp_res);
    exp_t e;
    int   cyc;
    @(negedge CLK);
    check({tag, "_inrdy"}, 64'(IN_READY), 64'd1);
    OP = op; X = x; Y = y; IN_VALID = 1'b1;
    e.res = exp_res; e.iseq = (x == y); e.lat = model_lat(op, x, y);
    sb.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    cyc = 1;
    while (!OUT_VALID && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, "_ovalid"}, 64'(OUT_VALID), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    check({tag, "_res"}, 64'(RESULT), 64'(e.res));
    check({tag, "_iseq"}, 64'(ISEQUAL), 64'(e.iseq));
    last_res = e.res;
  endtask

  task automatic consume(input string tag);
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check({tag, "_cons_ov"}, 64'(OUT_VALID), 64'd0);
    check({tag, "_cons_rdy"}, 64'(IN_READY), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res);
    issue_wait(tag, op, x, y, exp_res);
    consume(tag);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_inrdy", 64'(IN_READY), 64'd1);
    check("rst_ovalid", 64'(OUT_VALID), 64'd0);
    check("rst_res", 64'(RESULT), 64'd0);
    check("rst_iseq", 64'(ISEQUAL), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Directed corner cases
    run_op("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
    run_op("sra", 5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000);
    run_op("sll", 5'd5, 32'h0000_0003, 32'h24, 32'h0000_0030);
    run_op("slt", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_op("sltu", 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_op("xor_eq", 5'd4, 32'h1234_5678, 32'h1234_5678, 32'd0);
    run_op("mulh_min", 5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_lo", 5'd10, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB);
    run_op("div_neg", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_z", 5'd15, 32'd1234, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_z", 5'd17, 32'd1234, 32'd0, 32'd1234);
    run_op("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("divu_big", 5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    run_op("reserved", 5'd20, 32'd5, 32'd6, 32'd0);

    // Random ops checked against the bench model
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  op;
      logic [31:0] x, y;
      op = 5'($urandom_range(0, 20));
      x  = $urandom;
      y  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 7 == 0) y = x;
      run_op($sformatf("rnd%0d_op%0d", i, op), op, x, y, model(op, x, y));
    end

    // Backpressure: held result, no accept while DONE
    issue_wait("bp", 5'd0, 32'd5, 32'd7, 32'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      OP = 5'd1; X = 32'd100; Y = 32'd1; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      check($sformatf("bp_res%0d", i), 64'(RESULT), 64'd12);
      check($sformatf("bp_inrdy%0d", i), 64'(IN_READY), 64'd0);
      check($sformatf("bp_ov%0d", i), 64'(OUT_VALID), 64'd1);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    consume("bp");
    check("bp_after_res", 64'(RESULT), 64'd12);

    // Flush mid-divide
    start_op(5'd15, 32'hDEAD_BEEF, 32'd7);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    check("flush_inrdy", 64'(IN_READY), 64'd1);
    check("flush_ov", 64'(OUT_VALID), 64'd0);
    check("flush_res", 64'(RESULT), 64'(last_res));
    watch_no_valid("flush_noval", 40);
    run_op("post_flush", 5'd0, 32'd40, 32'd2, 32'd42);

    // Reset mid-multiply
    start_op(5'd10, 32'h0001_0003, 32'h0000_0101);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rstm_inrdy", 64'(IN_READY), 64'd1);
    check("rstm_ov", 64'(OUT_VALID), 64'd0);
    check("rstm_res", 64'(RESULT), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    watch_no_valid("rstm_noval", 40);
    run_op("post_rst", 5'd0, 32'hFFFF_FFFE, 32'd3, 32'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
